audio_fir_sequencer: RTL and testbench

Time-multiplexed FIR controller for the audio path. It detects each new sample frame on `AUD_DACLRCK` and writes the stereo sample into per-channel circular delay lines. It then runs a single shared 16×16 multiply-accumulate over all taps, left channel first and then right, and presents a saturated 16-bit result per channel. It sits between the codec receive word (`audioIn`) and the DAC transmit word (`audioOut`), and replaces per-tap parallel multipliers with one sequenced MAC and a selectable coefficient bank.

---
 rtl/audio_fir_sequencer.sv | 170 +++++++++++++++++
 tb/tb_audio_fir_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fir_sequencer.sv
// audio_fir_sequencer: frame-strobed stereo FIR using one shared 16x16 MAC,
// left channel first then right, with a selectable coefficient bank.
module audio_fir_sequencer #(
  parameter int unsigned TAPS  = 5,
  parameter int unsigned SHIFT = 14,
  parameter int unsigned ACC_W = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AUD_DACLRCK,
  input  logic [31:0] audioIn,
  input  logic [1:0]  bank_sel,
  input  logic        clear_overrun,
  output logic [31:0] audioOut,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned PTR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  // Coefficient banks h0..h4, h0 applies to the newest sample
  localparam logic signed [15:0] COEF [4][5] = '{
    '{16'sd0,     16'sd0,     16'sd16384, 16'sd0,     16'sd0    },
    '{16'sd2048,  16'sd4096,  16'sd4096,  16'sd4096,  16'sd2048 },
    '{-16'sd2048, -16'sd4096, 16'sd32767, -16'sd4096, -16'sd2048},
    '{16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0    }
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC_L,
    S_MAC_R,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic [1:0]               r_bank;
  logic signed [15:0]       r_x_l [TAPS];
  logic signed [15:0]       r_x_r [TAPS];
  logic [15:0]              r_res_l;
  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_sync_d;

  logic                     w_strobe;
  logic [PTR_W-1:0]         w_wptr_nxt;
  logic [PTR_W-1:0]         w_ridx;
  logic signed [15:0]       w_x;
  logic signed [15:0]       w_coef;
  logic signed [31:0]       w_prod;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [15:0]              w_sat;

  // Coefficient lookup; taps beyond the shipped table read as zero
  function automatic logic signed [15:0] coef(input logic [1:0] bank,
                                              input logic [PTR_W-1:0] k);
    coef = '0;
    if (32'(k) < 32'd5) coef = COEF[bank][k];
  endfunction

  // Arithmetic shift down to 16 bits with clamping instead of wrap
  function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > SAT_MAX)      sat16 = 16'h7FFF;
    else if (s < SAT_MIN) sat16 = 16'h8000;
    else                  sat16 = s[15:0];
  endfunction

  assign w_strobe   = r_sync2 & ~r_sync_d;
  assign w_wptr_nxt = (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
  // Read index (wptr - k) mod TAPS; true value is always below 2**PTR_W
  assign w_ridx     = (r_wptr >= r_k) ? r_wptr - r_k
                                      : r_wptr + PTR_W'(TAPS) - r_k;
  assign w_x        = (r_state == S_MAC_R) ? r_x_r[w_ridx] : r_x_l[w_ridx];
  assign w_coef     = coef(r_bank, r_k);
  assign w_prod     = 32'(w_coef) * 32'(w_x);
  assign w_acc_nxt  = r_acc + ACC_W'(w_prod);
  assign w_sat      = sat16(w_acc_nxt);

  // Frame-clock synchronizer, overrun flag and the sequencing FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_wptr    <= '0;
      r_k       <= '0;
      r_acc     <= '0;
      r_bank    <= '0;
      r_res_l   <= '0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync_d  <= 1'b0;
      audioOut  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_x_l[i] <= '0;
        r_x_r[i] <= '0;
      end
    end else begin
      r_sync1   <= AUD_DACLRCK;
      r_sync2   <= r_sync1;
      r_sync_d  <= r_sync2;
      out_valid <= 1'b0;

      // A dropped strobe takes priority over a simultaneous clear
      if (w_strobe && (r_state != S_IDLE)) overrun <= 1'b1;
      else if (clear_overrun)              overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            r_state <= S_LOAD;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_wptr            <= w_wptr_nxt;
          r_x_l[w_wptr_nxt] <= audioIn[31:16];
          r_x_r[w_wptr_nxt] <= audioIn[15:0];
          r_bank            <= bank_sel;
          r_acc             <= '0;
          r_k               <= '0;
          r_state           <= S_MAC_L;
        end
        S_MAC_L: begin
          if (r_k == LAST) begin
            r_res_l <= w_sat;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= S_MAC_R;
          end else begin
            r_acc <= w_acc_nxt;
            r_k   <= r_k + 1'b1;
          end
        end
        S_MAC_R: begin
          if (r_k == LAST) begin
            audioOut  <= {r_res_l, w_sat};
            out_valid <= 1'b1;
            r_acc     <= '0;
            r_k       <= '0;
            r_state   <= S_DONE;
          end else begin
            r_acc <= w_acc_nxt;
            r_k   <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_fir_sequencer.sv
// Bench for audio_fir_sequencer: directed scenarios plus random frames checked
// against a sliding-window FIR model.
module tb_audio_fir_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lrck;
  logic [31:0] audioIn;
  logic [1:0]  bank_sel;
  logic        clear_overrun;
  logic [31:0] audioOut;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  audio_fir_sequencer #(.TAPS(5), .SHIFT(14), .ACC_W(36)) dut (
    .clk           (clk),
    .rst           (rst),
    .AUD_DACLRCK   (lrck),
    .audioIn       (audioIn),
    .bank_sel      (bank_sel),
    .clear_overrun (clear_overrun),
    .audioOut      (audioOut),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: history windows with the newest sample at index 0
  int H [4][5] = '{
    '{0, 0, 16384, 0, 0},
    '{2048, 4096, 4096, 4096, 2048},
    '{-2048, -4096, 32767, -4096, -2048},
    '{0, 0, 0, 0, 0}
  };
  int          hist_l [5];
  int          hist_r [5];
  logic [31:0] exp_out;
  bit          ov_exp;

  // Per-frame options, restored to defaults after every frame
  int opt_dup;
  int opt_clr;
  int opt_rst;
  int opt_bank_late;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] fir_out(input int bank, input bit right);
    longint acc;
    acc = 0;
    for (int k = 0; k < 5; k++)
      acc += longint'(H[bank][k]) * longint'(right ? hist_r[k] : hist_l[k]);
    acc = acc >>> 14;
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 16'(acc);
  endfunction

  task automatic push(input logic signed [15:0] l, input logic signed [15:0] r);
    for (int k = 4; k > 0; k--) begin
      hist_l[k] = hist_l[k-1];
      hist_r[k] = hist_r[k-1];
    end
    hist_l[0] = int'(l);
    hist_r[0] = int'(r);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 5; k++) begin
      hist_l[k] = 0;
      hist_r[k] = 0;
    end
    exp_out = '0;
    ov_exp  = 1'b0;
  endtask

  // One frame: pin rises at c=0; output is due after the 14th rising edge
  task automatic run_frame(input logic signed [15:0] l, input logic signed [15:0] r,
                           input logic [1:0] bank);
    int          vcnt;
    int          vat;
    logic [31:0] want;
    vcnt = 0;
    vat  = -1;
    want = exp_out;
    audioIn  = {l, r};
    bank_sel = bank;
    if (opt_rst == 0) begin
      push(l, r);
      want = {fir_out(int'(bank), 1'b0), fir_out(int'(bank), 1'b1)};
    end
    if (opt_dup > 0) ov_exp = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (out_valid) begin
          vcnt++;
          if (vat < 0) vat = c;
        end
        if (c == 2)  check("busy_before_load", {31'd0, busy}, 32'd0);
        if (c == 3)  check("busy_in_load", {31'd0, busy}, 32'd1);
        if (c == 13) check("out_hold", audioOut, exp_out);
        if (c == 14) begin
          check("busy_in_done", {31'd0, busy}, (opt_rst > 0) ? 32'd0 : 32'd1);
          check("audio_out", audioOut, (opt_rst > 0) ? exp_out : want);
        end
        if (c == 15) check("busy_after_done", {31'd0, busy}, 32'd0);
        if (opt_rst > 0 && c == opt_rst + 1) begin
          check("rst_audio_out", audioOut, 32'd0);
          check("rst_busy", {31'd0, busy}, 32'd0);
          check("rst_overrun", {31'd0, overrun}, 32'd0);
        end
      end
      lrck = (c < 2) || (opt_dup > 0 && c >= opt_dup && c < opt_dup + 2);
      clear_overrun = (opt_clr != 0) && (opt_dup > 0) && (c == opt_dup + 2);
      if (opt_bank_late >= 0 && c == 6) bank_sel = 2'(opt_bank_late);
      if (opt_rst > 0) begin
        rst = (c != opt_rst);
        if (c == opt_rst) clear_model();
      end
    end
    check("valid_count", 32'(vcnt), (opt_rst > 0) ? 32'd0 : 32'd1);
    if (opt_rst == 0) begin
      check("valid_latency", 32'(vat), 32'd14);
      exp_out = want;
    end
    check("overrun_flag", {31'd0, overrun}, {31'd0, ov_exp});
    opt_dup       = 0;
    opt_clr       = 0;
    opt_rst       = 0;
    opt_bank_late = -1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    ov_exp = 1'b0;
    @(negedge clk);
    check("clear_overrun", {31'd0, overrun}, 32'd0);
  endtask

  function automatic logic signed [15:0] rand_sample();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h7FFF;
      1:       v = 16'h8000;
      default: v = 16'($urandom);
    endcase
    return $signed(v);
  endfunction

  initial begin
    opt_dup       = 0;
    opt_clr       = 0;
    opt_rst       = 0;
    opt_bank_late = -1;
    rst           = 1'b0;
    lrck          = 1'b0;
    audioIn       = '0;
    bank_sel      = '0;
    clear_overrun = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check("reset_audio_out", audioOut, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Bypass impulse: the sample reappears on the third frame
    run_frame(16'sh1000, -16'sh1000, 2'd0);
    run_frame(16'sd0, 16'sd0, 2'd0);
    run_frame(16'sd0, 16'sd0, 2'd0);
    check("impulse_center", audioOut, 32'h1000_F000);
    repeat (3) run_frame(16'sd0, 16'sd0, 2'd0);
    check("impulse_gone", audioOut, 32'd0);

    // Low-pass DC ramp and settle past the pointer wrap
    run_frame(16'sd1000, -16'sd1000, 2'd1);
    check("dc_first", audioOut, {16'd125, 16'hFF83});
    repeat (4) run_frame(16'sd1000, -16'sd1000, 2'd1);
    check("dc_settled", audioOut, {16'h03E8, 16'hFC18});
    repeat (3) run_frame(16'sd1000, -16'sd1000, 2'd1);
    check("dc_wrapped", audioOut, {16'h03E8, 16'hFC18});

    // Sharpen with full-scale alternating input
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run_frame(16'sh7FFF, -16'sh8000, 2'd2);
      else            run_frame(-16'sh8000, 16'sh7FFF, 2'd2);
    end

    // Overrun: dropped second strobe, clear alone, then set and clear together
    opt_dup = 4;
    run_frame(16'sd300, -16'sd700, 2'd1);
    pulse_clear();
    run_frame(16'sd50, 16'sd60, 2'd1);
    opt_dup = 6;
    opt_clr = 1;
    run_frame(16'sd1234, -16'sd4321, 2'd1);
    pulse_clear();

    // Reset in the middle of the right-channel pass
    run_frame(16'sd2000, 16'sd3000, 2'd1);
    opt_rst = 10;
    run_frame(16'sd4000, 16'sd5000, 2'd1);
    run_frame(16'sd0, 16'sd0, 2'd0);

    // Bank change while busy applies to the next frame only
    opt_bank_late = 3;
    run_frame(16'sd777, -16'sd888, 2'd0);
    run_frame(16'sd999, 16'sd555, 2'd3);
    check("bank_mute", audioOut, 32'd0);

    // Random frames
    for (int i = 0; i < 40; i++) begin
      run_frame(rand_sample(), rand_sample(), 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
